resp_demux2: RTL and testbench

- Response-side counterpart of the core's 2:1 request mux. Two requesters (0 = instruction fetch, 1 = load/store) share one in-order memory port.
- The block records, in issue order, which requester owns each accepted request. It steers each returning response to that requester through a registered valid/ready output stage.
- It sits between the shared memory response channel and the fetch/LSU response inputs.

---
 rtl/resp_demux_pkg.sv | 8 +
 rtl/owner_fifo.sv | 60 ++++++
 rtl/resp_demux2.sv | 100 ++++++++++
 tb/tb_resp_demux2.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/resp_demux_pkg.sv
// Shared types and defaults for the response demultiplexer.
package resp_demux_pkg;

   typedef enum logic { OWNER_IFETCH = 1'b0, OWNER_LSU = 1'b1 } owner_e;

   localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit owner tags; DEPTH must be a power of two >= 2.
module owner_fifo
   import resp_demux_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  owner_e                   din,
   input  logic                     pop,
   output owner_e                   dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   owner_e             mem [DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rptr];
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is only taken when a pop frees the slot this cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (do_pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/resp_demux2.sv
// Steers in-order memory responses to fetch (0) or LSU (1) via registered output slots.
// Optional RESP_DEMUX_ERR_EN adds sticky err_o for overflow pushes and stray responses.
module resp_demux2
   import resp_demux_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_fire_i,
   input  logic                  req_sel_i,
   output logic                  req_stall_o,
   input  logic                  resp_valid_i,
   input  logic [DATA_WIDTH-1:0] resp_data_i,
   output logic                  resp_ready_o,
   output logic                  out0_valid_o,
   output logic [DATA_WIDTH-1:0] out0_data_o,
   input  logic                  out0_ready_i,
   output logic                  out1_valid_o,
   output logic [DATA_WIDTH-1:0] out1_data_o,
   input  logic                  out1_ready_i,
   output logic                  idle_o
`ifdef RESP_DEMUX_ERR_EN
   ,
   output logic                  err_o
`endif
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   owner_e            head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  count;
   logic              accept0;
   logic              accept1;
   logic              hs;
   logic              load0;
   logic              load1;

   owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_fire_i),
      .din   (owner_e'(req_sel_i)),
      .pop   (hs),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   // Only the head owner's slot matters: a stalled head blocks the other requester.
   assign accept0      = !out0_valid_o || out0_ready_i;
   assign accept1      = !out1_valid_o || out1_ready_i;
   assign resp_ready_o = !fifo_empty && ((head == OWNER_LSU) ? accept1 : accept0);
   assign hs           = resp_valid_i && resp_ready_o;
   assign load0        = hs && (head == OWNER_IFETCH);
   assign load1        = hs && (head == OWNER_LSU);

   assign req_stall_o  = fifo_full;
   assign idle_o       = (count == '0) && !out0_valid_o && !out1_valid_o;

   // Output slots: a full slot being drained reloads in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out0_valid_o <= 1'b0;
         out0_data_o  <= '0;
         out1_valid_o <= 1'b0;
         out1_data_o  <= '0;
      end else begin
         if (load0) begin
            out0_valid_o <= 1'b1;
            out0_data_o  <= resp_data_i;
         end else if (out0_ready_i) begin
            out0_valid_o <= 1'b0;
         end
         if (load1) begin
            out1_valid_o <= 1'b1;
            out1_data_o  <= resp_data_i;
         end else if (out1_ready_i) begin
            out1_valid_o <= 1'b0;
         end
      end
   end

`ifdef RESP_DEMUX_ERR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_o <= 1'b0;
      end else if ((req_fire_i && fifo_full && !hs) || (resp_valid_i && fifo_empty)) begin
         err_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_resp_demux2.sv
// Directed table-driven bench for resp_demux2; outputs sampled before each rising edge.
module tb_resp_demux2;

   logic        clk;
   logic        rst_n;
   logic        req_fire;
   logic        req_sel;
   logic        req_stall;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_ready;
   logic        out0_valid;
   logic [31:0] out0_data;
   logic        out0_ready;
   logic        out1_valid;
   logic [31:0] out1_data;
   logic        out1_ready;
   logic        idle;
`ifdef RESP_DEMUX_ERR_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;

   resp_demux2 #(
      .DATA_WIDTH      (32),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_fire_i   (req_fire),
      .req_sel_i    (req_sel),
      .req_stall_o  (req_stall),
      .resp_valid_i (resp_valid),
      .resp_data_i  (resp_data),
      .resp_ready_o (resp_ready),
      .out0_valid_o (out0_valid),
      .out0_data_o  (out0_data),
      .out0_ready_i (out0_ready),
      .out1_valid_o (out1_valid),
      .out1_data_o  (out1_data),
      .out1_ready_i (out1_ready),
      .idle_o       (idle)
`ifdef RESP_DEMUX_ERR_EN
      ,
      .err_o        (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, fire, sel, rv;
      logic [31:0] rd;
      logic        r0, r1;
      logic        rr, stall, v0;
      logic [31:0] d0;
      logic        v1;
      logic [31:0] d1;
      logic        idle;
   } vec_t;

   function automatic vec_t mk(input logic rn, fi, se, rv, input logic [31:0] rd,
                               input logic r0, r1, rr, st, v0, input logic [31:0] d0,
                               input logic v1, input logic [31:0] d1, input logic id);
      vec_t v;
      v.rst_n = rn; v.fire = fi; v.sel = se; v.rv = rv; v.rd = rd; v.r0 = r0; v.r1 = r1;
      v.rr = rr; v.stall = st; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.idle = id;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      @(negedge clk);
      rst_n = v.rst_n; req_fire = v.fire; req_sel = v.sel;
      resp_valid = v.rv; resp_data = v.rd; out0_ready = v.r0; out1_ready = v.r1;
      #2;
      chk({tag, ".resp_ready"}, idx, 32'(resp_ready), 32'(v.rr));
      chk({tag, ".req_stall"},  idx, 32'(req_stall),  32'(v.stall));
      chk({tag, ".out0_valid"}, idx, 32'(out0_valid), 32'(v.v0));
      chk({tag, ".out0_data"},  idx, out0_data,       v.d0);
      chk({tag, ".out1_valid"}, idx, 32'(out1_valid), 32'(v.v1));
      chk({tag, ".out1_data"},  idx, out1_data,       v.d1);
      chk({tag, ".idle"},       idx, 32'(idle),       32'(v.idle));
   endtask

   localparam logic [31:0] DE = 32'hDEADBEEF, A = 32'h11111111, B = 32'h22222222;
   localparam logic [31:0] C = 32'h33333333, D = 32'h44444444, E = 32'h55555555;
   localparam logic [31:0] F = 32'h66666666, S7 = 32'h77777777, G = 32'h88888888;
   localparam logic [31:0] H = 32'h99999999, I = 32'hAAAAAAAA, J = 32'hBBBBBBBB;
   localparam logic [31:0] K = 32'hCCCCCCCC, L = 32'hDDDDDDDD, E0 = 32'hE0E0E0E0;
   localparam logic [31:0] F0 = 32'hF0F0F0F0, X = 32'h12345678;

   vec_t tbl[$];
   vec_t fullq[$];
   vec_t midq[$];

   initial begin
      // Columns: rst_n fire sel rv rd r0 r1 | rr stall v0 d0 v1 d1 idle
      // reset state, single fetch
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,0,0 ,0,0,1));
      tbl.push_back(mk(1,1,0,0,0 ,1,1, 0,0,0,0 ,0,0,1));
      tbl.push_back(mk(1,0,0,1,DE,1,1, 1,0,0,0 ,0,0,0));
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,1,DE,0,0,0));
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,0,DE,0,0,1));
      // interleave 0,1,1,0 then A,B,C,D
      tbl.push_back(mk(1,1,0,0,0 ,1,1, 0,0,0,DE,0,0,1));
      tbl.push_back(mk(1,1,1,0,0 ,1,1, 1,0,0,DE,0,0,0));
      tbl.push_back(mk(1,1,1,0,0 ,1,1, 1,0,0,DE,0,0,0));
      tbl.push_back(mk(1,1,0,0,0 ,1,1, 1,0,0,DE,0,0,0));
      tbl.push_back(mk(1,0,0,1,A ,1,1, 1,1,0,DE,0,0,0));
      tbl.push_back(mk(1,0,0,1,B ,1,1, 1,0,1,A ,0,0,0));
      tbl.push_back(mk(1,0,0,1,C ,1,1, 1,0,0,A ,1,B,0));
      tbl.push_back(mk(1,0,0,1,D ,1,1, 1,0,0,A ,1,C,0));
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,1,D ,0,C,0));
      // backpressure on slot 1
      tbl.push_back(mk(1,1,1,0,0 ,1,0, 0,0,0,D ,0,C,1));
      tbl.push_back(mk(1,1,1,1,E ,1,0, 1,0,0,D ,0,C,0));
      tbl.push_back(mk(1,0,0,1,F ,1,0, 0,0,0,D ,1,E,0));
      tbl.push_back(mk(1,0,0,1,F ,1,0, 0,0,0,D ,1,E,0));
      tbl.push_back(mk(1,0,0,1,F ,1,1, 1,0,0,D ,1,E,0));
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,0,D ,1,F,0));
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,0,D ,0,F,1));
      // stray response held off, then accepted once a tag exists
      tbl.push_back(mk(1,0,0,1,S7,1,1, 0,0,0,D ,0,F,1));
      tbl.push_back(mk(1,1,0,0,0 ,1,1, 0,0,0,D ,0,F,1));
      tbl.push_back(mk(1,0,0,1,S7,1,1, 1,0,0,D ,0,F,0));
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,1,S7,0,F,0));
      tbl.push_back(mk(1,0,0,0,0 ,1,1, 0,0,0,S7,0,F,1));

      // full: fire+resp while full, dropped push, drain in order
      fullq.push_back(mk(1,1,0,0,0 ,1,1, 0,0,0,S7,0,F,1));
      fullq.push_back(mk(1,1,0,0,0 ,1,1, 1,0,0,S7,0,F,0));
      fullq.push_back(mk(1,1,0,0,0 ,1,1, 1,0,0,S7,0,F,0));
      fullq.push_back(mk(1,1,0,0,0 ,1,1, 1,0,0,S7,0,F,0));
      fullq.push_back(mk(1,1,1,1,G ,1,1, 1,1,0,S7,0,F,0));
      fullq.push_back(mk(1,1,0,0,0 ,1,1, 1,1,1,G ,0,F,0));
      fullq.push_back(mk(1,0,0,1,H ,1,1, 1,1,0,G ,0,F,0));
      fullq.push_back(mk(1,0,0,1,I ,1,1, 1,0,1,H ,0,F,0));
      fullq.push_back(mk(1,0,0,1,J ,1,1, 1,0,1,I ,0,F,0));
      fullq.push_back(mk(1,0,0,1,K ,1,1, 1,0,1,J ,0,F,0));
      fullq.push_back(mk(1,0,0,1,L ,1,1, 0,0,0,J ,1,K,0));
      fullq.push_back(mk(1,0,0,0,0 ,1,1, 0,0,0,J ,0,K,1));

      // mid-flight reset with 3 tags outstanding and slot 0 held
      midq.push_back(mk(1,1,0,0,0 ,0,1, 0,0,0,J ,0,K,1));
      midq.push_back(mk(1,1,1,1,E0,0,1, 1,0,0,J ,0,K,0));
      midq.push_back(mk(1,1,0,0,0 ,0,1, 1,0,1,E0,0,K,0));
      midq.push_back(mk(1,1,1,0,0 ,0,1, 1,0,1,E0,0,K,0));
      midq.push_back(mk(0,1,1,1,F0,0,1, 1,0,1,E0,0,K,0));
      midq.push_back(mk(1,0,0,0,0 ,0,1, 0,0,0,0 ,0,0,1));
      midq.push_back(mk(1,1,1,0,0 ,1,1, 0,0,0,0 ,0,0,1));
      midq.push_back(mk(1,0,0,1,X ,1,1, 1,0,0,0 ,0,0,0));
      midq.push_back(mk(1,0,0,0,0 ,1,1, 0,0,0,0 ,1,X,0));

      rst_n = 1'b0; req_fire = 1'b0; req_sel = 1'b0; resp_valid = 1'b0;
      resp_data = '0; out0_ready = 1'b1; out1_ready = 1'b1;
      repeat (2) @(posedge clk);
`ifdef RESP_DEMUX_ERR_EN
      #1 chk("err_after_reset", 0, 32'(err), 32'd0);
`endif

      foreach (tbl[i])   apply(tbl[i],   "tbl",  i);
      foreach (fullq[i]) apply(fullq[i], "full", i);
`ifdef RESP_DEMUX_ERR_EN
      chk("err_sticky", 0, 32'(err), 32'd1);
`endif
      foreach (midq[i])  apply(midq[i],  "mid",  i);
`ifdef RESP_DEMUX_ERR_EN
      chk("err_cleared", 0, 32'(err), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
